// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package fetch_pkg;

    localparam int INSTR_W          = 32;
    localparam int DEFAULT_ADDR_W   = 12;
    localparam int DEFAULT_RESET_PC = 0;

    // RUN issues fetches; FAULT parks the front end after a misaligned redirect.
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // One buffered instruction together with the PC it was fetched from
    // (sized for the default address width).
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]        instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch bus: program-memory port, redirect input, decode handshake and fault
// report. Decode handshake: an instruction transfers in any cycle where
// instr_valid_o and instr_ready_i are both high; instr_valid_o does not wait on
// instr_ready_i, and the head stays stable while valid is high and ready is low,
// unless a redirect flushes it.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic                enable_i;
    logic [ADDR_W-1:0]   imem_addr_o;
    logic [INSTR_W-1:0]  imem_data_i;
    logic                redirect_valid_i;
    logic [ADDR_W-1:0]   redirect_pc_i;
    logic                instr_valid_o;
    logic [INSTR_W-1:0]  instr_o;
    logic [ADDR_W-1:0]   instr_pc_o;
    logic                instr_ready_i;
    logic                fault_o;
    logic [ADDR_W-1:0]   fault_pc_o;
    fetch_state_t        state_dbg_o;

    modport master (
        input  enable_i, imem_data_i, redirect_valid_i, redirect_pc_i, instr_ready_i,
        output imem_addr_o, instr_valid_o, instr_o, instr_pc_o, fault_o, fault_pc_o,
        output state_dbg_o
    );

    modport slave (
        output enable_i, imem_data_i, redirect_valid_i, redirect_pc_i, instr_ready_i,
        input  imem_addr_o, instr_valid_o, instr_o, instr_pc_o, fault_o, fault_pc_o,
        input  state_dbg_o
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered head. Flush beats push and pop;
// a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module fetch_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = head_q;
    assign rd_nxt  = rd_ptr_q + PTR_W'(1);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers, occupancy and head value.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_nxt;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // New data becomes the head when nothing older will remain.
            if (do_push && (empty_o || (do_pop && count_q == CNT_W'(1)))) begin
                head_d = data_i;
            end else if (do_pop && count_q > CNT_W'(1)) begin
                head_d = mem_q[rd_nxt];
            end
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage write; the slot being popped may be reused in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!flush_i && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives the program-memory address,
// buffers {pc, word} pairs for decode and handles redirects and misaligned faults.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int          ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    fetch_if.master bus
);
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               fault_q, fault_d;
    logic [ADDR_W-1:0]  fault_pc_q, fault_pc_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               redirect_aligned;
    logic               instr_valid;
    logic               pop;
    logic               fetch;

    assign redirect_aligned = (bus.redirect_pc_i[1:0] == 2'b00);
    assign instr_valid      = !fifo_empty && (state_q == RUN);
    assign pop              = instr_valid && bus.instr_ready_i;
    // A fetch may land in a full buffer only when decode frees the head this cycle.
    assign fetch            = (state_q == RUN) && bus.enable_i && !bus.redirect_valid_i
                              && (!fifo_full || pop);

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fetch),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid_i),
        .data_i  ({pc_q, bus.imem_data_i}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_valid_o = instr_valid;
    assign bus.instr_o       = fifo_head[INSTR_W-1:0];
    assign bus.instr_pc_o    = fifo_head[ENTRY_W-1 -: ADDR_W];
    assign bus.fault_o       = fault_q;
    assign bus.fault_pc_o    = fault_pc_q;
    assign bus.state_dbg_o   = state_q;

    // Next state, PC and fault bookkeeping; redirects outrank fetches.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            RUN: begin
                if (bus.redirect_valid_i) begin
                    if (redirect_aligned) begin
                        pc_d = bus.redirect_pc_i;
                    end else begin
                        fault_d    = 1'b1;
                        fault_pc_d = bus.redirect_pc_i;
                        state_d    = FAULT;
                    end
                end else if (fetch) begin
                    pc_d = pc_q + ADDR_W'(4);
                end
            end
            FAULT: begin
                if (bus.redirect_valid_i) begin
                    if (redirect_aligned) begin
                        pc_d    = bus.redirect_pc_i;
                        fault_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        fault_pc_d = bus.redirect_pc_i;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State, PC and fault registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            pc_q       <= ADDR_W'(RESET_PC);
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios followed by random traffic,
// all checked against a queue-based model of the fetch buffer.
module tb_fetch_controller;
    import fetch_pkg::*;

    localparam int          AW     = 12;
    localparam int          DEPTH  = 2;
    localparam logic [AW-1:0] RST_PC = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_if #(.ADDR_W(AW)) bus ();

    fetch_controller #(
        .ADDR_W     (AW),
        .RESET_PC   (0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Program memory: combinational, word indexed by the byte address.
    logic [31:0] imem [0:1023];
    assign bus.imem_data_i = imem[bus.imem_addr_o[AW-1:2]];

    // Reference model state.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_fault_pc;
    bit            m_fault;
    logic [AW-1:0] q_pc[$];
    logic [31:0]   q_instr[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = (q_pc.size() > 0) && !m_fault;
        check("valid", 64'(bus.instr_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            check("instr", 64'(bus.instr_o), 64'(q_instr[0]));
            check("instr_pc", 64'(bus.instr_pc_o), 64'(q_pc[0]));
        end
        check("imem_addr", 64'(bus.imem_addr_o), 64'(m_pc));
        check("fault", 64'(bus.fault_o), 64'(m_fault));
        check("fault_pc", 64'(bus.fault_pc_o), 64'(m_fault_pc));
        check("state", 64'(bus.state_dbg_o == FAULT), 64'(m_fault));
    endtask

    task automatic drive_idle();
        bus.enable_i         = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.instr_ready_i    = 1'b0;
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_instr.delete();
        m_pc       = RST_PC;
        m_fault    = 1'b0;
        m_fault_pc = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs();
        check("reset_instr", 64'(bus.instr_o), 64'(0));
        check("reset_instr_pc", 64'(bus.instr_pc_o), 64'(0));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cycle(input bit en, input bit rv, input logic [AW-1:0] rpc, input bit rdy);
        bit pop;
        bus.enable_i         = en;
        bus.redirect_valid_i = rv;
        bus.redirect_pc_i    = rpc;
        bus.instr_ready_i    = rdy;
        pop = (q_pc.size() > 0) && !m_fault && rdy;
        if (rv) begin
            q_pc.delete();
            q_instr.delete();
            if (rpc[1:0] == 2'b00) begin
                m_pc    = rpc;
                m_fault = 1'b0;
            end else begin
                m_fault    = 1'b1;
                m_fault_pc = rpc;
            end
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_instr.pop_front());
            end
            if (!m_fault && en && q_pc.size() < DEPTH) begin
                q_pc.push_back(m_pc);
                q_instr.push_back(imem[m_pc[AW-1:2]]);
                m_pc = m_pc + AW'(4);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        drive_idle();
        for (int i = 0; i < 1024; i++) imem[i] = $urandom;
        imem[0] = 32'h0000_0013;
        imem[1] = 32'h0010_0093;
        imem[2] = 32'h0020_0113;

        // Straight-line fetch with decode always ready.
        do_reset();
        cycle(1, 0, '0, 1);
        check("seq_w0", 64'(bus.instr_o), 64'h0000_0013);
        check("seq_pc0", 64'(bus.instr_pc_o), 64'h000);
        cycle(1, 0, '0, 1);
        check("seq_w1", 64'(bus.instr_o), 64'h0010_0093);
        check("seq_pc1", 64'(bus.instr_pc_o), 64'h004);
        cycle(1, 0, '0, 1);
        check("seq_w2", 64'(bus.instr_o), 64'h0020_0113);
        check("seq_pc2", 64'(bus.instr_pc_o), 64'h008);

        // Decode stall for four cycles, then drain.
        do_reset();
        repeat (4) cycle(1, 0, '0, 0);
        check("stall_pc_hold", 64'(bus.imem_addr_o), 64'h008);
        check("stall_head", 64'(bus.instr_pc_o), 64'h000);
        cycle(1, 0, '0, 1);
        check("drain_0", 64'(bus.instr_pc_o), 64'h004);
        cycle(1, 0, '0, 1);
        check("drain_1", 64'(bus.instr_pc_o), 64'h008);

        // Redirect while a pop is happening.
        cycle(1, 1, 12'h100, 1);
        check("redir_flush", 64'(bus.instr_valid_o), 64'(0));
        cycle(1, 0, '0, 1);
        check("redir_target", 64'(bus.instr_pc_o), 64'h100);

        // Misaligned redirect, then recovery.
        cycle(1, 1, 12'h102, 1);
        check("fault_set", 64'(bus.fault_o), 64'(1));
        check("fault_pc", 64'(bus.fault_pc_o), 64'h102);
        repeat (2) cycle(1, 0, '0, 1);
        check("fault_novalid", 64'(bus.instr_valid_o), 64'(0));
        cycle(1, 1, 12'h200, 1);
        check("fault_clear", 64'(bus.fault_o), 64'(0));
        cycle(1, 0, '0, 1);
        check("fault_recover_pc", 64'(bus.instr_pc_o), 64'h200);

        // Address wrap-around.
        cycle(1, 1, 12'hFFC, 1);
        cycle(1, 0, '0, 1);
        check("wrap_pc0", 64'(bus.instr_pc_o), 64'hFFC);
        cycle(1, 0, '0, 1);
        check("wrap_pc1", 64'(bus.instr_pc_o), 64'h000);

        // Asynchronous reset with a full buffer.
        do_reset();
        repeat (3) cycle(1, 0, '0, 0);
        check("pre_async_valid", 64'(bus.instr_valid_o), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_valid", 64'(bus.instr_valid_o), 64'(0));
        check("async_addr", 64'(bus.imem_addr_o), 64'(RST_PC));
        do_reset();
        cycle(1, 0, '0, 1);
        check("post_reset_pc", 64'(bus.instr_pc_o), 64'(RST_PC));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit            en;
            bit            rv;
            bit            rdy;
            logic [AW-1:0] rpc;
            en  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) rpc = AW'($urandom_range(0, 4095));
            else                           rpc = AW'($urandom_range(0, 1023) * 4);
            cycle(en, rv, rpc, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
